// File: rtl/lat_meas_clk27_if.sv
// Control, sensor and result signals between the sys controller / scanconverter
// output stage and the clk27 latency tester.
interface lat_meas_clk27_if;
    logic        active_i;
    logic        armed_i;
    logic [1:0]  mode_i;
    logic        sensor_i;
    logic        vsync_i;
    logic        trigger_i;
    logic [1:0]  mode_synced_o;
    logic [15:0] lat_result_o;
    logic [11:0] stb_result_o;
    logic        trig_waiting_o;
    logic        finished_o;

    modport master (
        output active_i, armed_i, mode_i, sensor_i, vsync_i, trigger_i,
        input  mode_synced_o, lat_result_o, stb_result_o, trig_waiting_o, finished_o
    );

    modport slave (
        input  active_i, armed_i, mode_i, sensor_i, vsync_i, trigger_i,
        output mode_synced_o, lat_result_o, stb_result_o, trig_waiting_o, finished_o
    );
endinterface

// File: rtl/lat_meas_clk27.sv
// Display latency tester: counts ticks from a reference event (trigger or the
// following VSYNC edge) to light on the sensor, then measures sensor settle time.
module lat_meas_clk27 #(
    parameter int unsigned TICK_DIV     = 2700,
    parameter int unsigned STABLE_TICKS = 10,
    parameter bit          DET_LEVEL    = 1'b0
) (
    input  logic            clk27,
    input  logic            reset_n,
    lat_meas_clk27_if.slave lt
);

    localparam int unsigned     PW            = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST    = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]   PRESC_ZERO    = PW'(0);
    localparam logic [PW-1:0]   PRESC_ONE     = PW'(1);
    localparam int unsigned     SW            = $clog2(STABLE_TICKS + 1);
    localparam logic [SW-1:0]   STABLE_TARGET = SW'(STABLE_TICKS);
    localparam logic [SW-1:0]   STABLE_ZERO   = SW'(0);
    localparam logic [SW-1:0]   STABLE_ONE    = SW'(1);
    localparam logic [15:0]     LAT_MAX       = 16'hFFFF;
    localparam logic [11:0]     STB_MAX       = 12'hFFF;
    localparam logic [11:0]     STB_DROP      = 12'(STABLE_TICKS);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_TRIG = 3'd1,
        WAIT_REF  = 3'd2,
        COUNT_LAT = 3'd3,
        COUNT_STB = 3'd4,
        DONE      = 3'd5
    } state_t;

    state_t        state_r;
    logic          vs_meta_r, vs_sync_r, vs_prev_r;
    logic          tr_meta_r, tr_sync_r, tr_prev_r;
    logic [PW-1:0] presc_r;
    logic [SW-1:0] stable_r;
    logic [1:0]    mode_r;
    logic [15:0]   lat_r;
    logic [11:0]   stb_r;
    logic          waiting_r;
    logic          finished_r;

    logic          trig_rise_s;
    logic          trig_low_s;
    logic          vs_lead_s;
    logic          vs_trail_s;
    logic          tick_s;
    logic          det_s;
    logic          ref_hit_s;
    logic          direct_s;
    logic [PW-1:0] presc_next_s;
    logic [15:0]   lat_inc_s;
    logic [11:0]   stb_inc_s;
    logic [11:0]   stb_final_s;
    logic [SW-1:0] stable_inc_s;

    // Two-flop synchronizers plus a history flop; VSYNC idles high so its chain resets high
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            vs_meta_r <= 1'b1;
            vs_sync_r <= 1'b1;
            vs_prev_r <= 1'b1;
            tr_meta_r <= 1'b0;
            tr_sync_r <= 1'b0;
            tr_prev_r <= 1'b0;
        end else begin
            vs_meta_r <= lt.vsync_i;
            vs_sync_r <= vs_meta_r;
            vs_prev_r <= vs_sync_r;
            tr_meta_r <= lt.trigger_i;
            tr_sync_r <= tr_meta_r;
            tr_prev_r <= tr_sync_r;
        end
    end

    // Edge detects, tick strobe and saturating next values for the counters
    always_comb begin
        trig_rise_s  = tr_sync_r & ~tr_prev_r;
        trig_low_s   = ~tr_sync_r;
        vs_lead_s    = vs_prev_r & ~vs_sync_r;
        vs_trail_s   = vs_sync_r & ~vs_prev_r;
        tick_s       = (presc_r == PRESC_LAST);
        det_s        = (lt.sensor_i == DET_LEVEL);
        ref_hit_s    = ((mode_r == 2'd1) && vs_lead_s) || ((mode_r == 2'd2) && vs_trail_s);
        direct_s     = (mode_r == 2'd0) || (mode_r == 2'd3);
        presc_next_s = tick_s ? PRESC_ZERO : (presc_r + PRESC_ONE);

        if (tick_s && (lat_r != LAT_MAX)) begin
            lat_inc_s = lat_r + 16'd1;
        end else begin
            lat_inc_s = lat_r;
        end

        if (tick_s && (stb_r != STB_MAX)) begin
            stb_inc_s = stb_r + 12'd1;
        end else begin
            stb_inc_s = stb_r;
        end

        // Any cycle without light restarts the stability run
        if (!det_s) begin
            stable_inc_s = STABLE_ZERO;
        end else if (tick_s) begin
            stable_inc_s = stable_r + STABLE_ONE;
        end else begin
            stable_inc_s = stable_r;
        end

        if (stb_inc_s >= STB_DROP) begin
            stb_final_s = stb_inc_s - STB_DROP;
        end else begin
            stb_final_s = 12'd0;
        end
    end

    // Measurement sequencer with registered status and result outputs
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            presc_r    <= PRESC_ZERO;
            stable_r   <= STABLE_ZERO;
            mode_r     <= 2'd0;
            lat_r      <= 16'd0;
            stb_r      <= 12'd0;
            waiting_r  <= 1'b0;
            finished_r <= 1'b0;
        end else if (!lt.active_i) begin
            state_r    <= IDLE;
            presc_r    <= PRESC_ZERO;
            waiting_r  <= 1'b0;
            finished_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    presc_r   <= PRESC_ZERO;
                    waiting_r <= 1'b0;
                    if (lt.armed_i) begin
                        mode_r     <= lt.mode_i;
                        lat_r      <= 16'd0;
                        stb_r      <= 12'd0;
                        finished_r <= 1'b0;
                        waiting_r  <= 1'b1;
                        state_r    <= WAIT_TRIG;
                    end
                end
                WAIT_TRIG: begin
                    if (!lt.armed_i) begin
                        state_r    <= IDLE;
                        waiting_r  <= 1'b0;
                        finished_r <= 1'b0;
                    end else if (trig_rise_s) begin
                        waiting_r <= 1'b0;
                        presc_r   <= PRESC_ZERO;
                        state_r   <= direct_s ? COUNT_LAT : WAIT_REF;
                    end
                end
                WAIT_REF: begin
                    if (!lt.armed_i) begin
                        state_r    <= IDLE;
                        finished_r <= 1'b0;
                    end else if (trig_low_s) begin
                        waiting_r <= 1'b1;
                        state_r   <= WAIT_TRIG;
                    end else if (ref_hit_s) begin
                        presc_r <= PRESC_ZERO;
                        state_r <= COUNT_LAT;
                    end
                end
                COUNT_LAT: begin
                    if (!lt.armed_i) begin
                        state_r    <= IDLE;
                        presc_r    <= PRESC_ZERO;
                        finished_r <= 1'b0;
                    end else begin
                        presc_r <= presc_next_s;
                        lat_r   <= lat_inc_s;
                        if (lat_inc_s == LAT_MAX) begin
                            stb_r      <= STB_MAX;
                            finished_r <= 1'b1;
                            state_r    <= DONE;
                        end else if (det_s) begin
                            stable_r <= STABLE_ZERO;
                            presc_r  <= PRESC_ZERO;
                            state_r  <= COUNT_STB;
                        end
                    end
                end
                COUNT_STB: begin
                    if (!lt.armed_i) begin
                        state_r    <= IDLE;
                        presc_r    <= PRESC_ZERO;
                        finished_r <= 1'b0;
                    end else begin
                        presc_r  <= presc_next_s;
                        stb_r    <= stb_inc_s;
                        stable_r <= stable_inc_s;
                        // The stable run itself is not part of the settle time
                        if (stable_inc_s == STABLE_TARGET) begin
                            stb_r      <= stb_final_s;
                            finished_r <= 1'b1;
                            state_r    <= DONE;
                        end else if (stb_inc_s == STB_MAX) begin
                            finished_r <= 1'b1;
                            state_r    <= DONE;
                        end
                    end
                end
                DONE: begin
                    presc_r    <= PRESC_ZERO;
                    finished_r <= 1'b1;
                    if (!lt.armed_i) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    presc_r    <= PRESC_ZERO;
                    waiting_r  <= 1'b0;
                    finished_r <= 1'b0;
                end
            endcase
        end
    end

    assign lt.mode_synced_o  = mode_r;
    assign lt.lat_result_o   = lat_r;
    assign lt.stb_result_o   = stb_r;
    assign lt.trig_waiting_o = waiting_r;
    assign lt.finished_o     = finished_r;

endmodule

// File: tb/tb_lat_meas_clk27.sv
// Bench for lat_meas_clk27: directed and randomized measurements checked against
// tick arithmetic derived from event cycle numbers; a TICK_DIV=1 instance covers saturation.
module tb_lat_meas_clk27;

    localparam int T  = 7;
    localparam int ST = 10;

    logic clk27   = 1'b0;
    logic reset_n = 1'b0;
    int   cyc     = 0;
    int   total   = 0;
    int   bad     = 0;
    int   last_lat = 0;
    int   last_stb = 0;

    lat_meas_clk27_if ifm ();
    lat_meas_clk27_if ifs ();

    lat_meas_clk27 #(.TICK_DIV(T), .STABLE_TICKS(ST), .DET_LEVEL(1'b0)) dut (
        .clk27  (clk27),
        .reset_n(reset_n),
        .lt     (ifm.slave)
    );

    lat_meas_clk27 #(.TICK_DIV(1), .STABLE_TICKS(ST), .DET_LEVEL(1'b0)) dut_sat (
        .clk27  (clk27),
        .reset_n(reset_n),
        .lt     (ifs.slave)
    );

    always #5 clk27 = ~clk27;

    always @(posedge clk27) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk27);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One measurement; expectations come from the cycle numbers of the reference
    // event (E), the detection sample (S) and the last dark sample (L).
    task automatic measure(input int m, input int ref_delay, input int gap, input int pieces);
        int tc, e, s, l, q, exp_done, n;
        ifm.vsync_i   = (m == 2) ? 1'b0 : 1'b1;
        ifm.sensor_i  = 1'b1;
        ifm.trigger_i = 1'b0;
        step(4);
        ifm.mode_i  = 2'(m);
        ifm.armed_i = 1'b1;
        step(1);
        check("arm_waiting", ifm.trig_waiting_o, 1);
        check("arm_mode", ifm.mode_synced_o, m);
        check("arm_clear", {ifm.finished_o, ifm.stb_result_o, ifm.lat_result_o}, 0);
        step(2);
        ifm.trigger_i = 1'b1;
        tc = cyc;
        step(2);
        check("trig_wait_pre", ifm.trig_waiting_o, 1);
        step(1);
        check("trig_wait_post", ifm.trig_waiting_o, 0);
        if (m == 1 || m == 2) begin
            step(ref_delay + T);
            check("ref_no_count", ifm.lat_result_o, 0);
            ifm.vsync_i = ~ifm.vsync_i;
            e = cyc + 3;
            step(3);
        end else begin
            e = tc + 3;
        end
        step(gap);
        ifm.sensor_i = 1'b0;
        s = cyc + 1;
        l = s;
        for (int p = 0; p < pieces; p++) begin
            step($urandom_range(1, (ST - 1) * T));
            ifm.sensor_i = 1'b1;
            step($urandom_range(1, 3));
            l = cyc;
            ifm.sensor_i = 1'b0;
        end
        q = (pieces > 0) ? (l - s) / T : 0;
        exp_done = s + (q + ST) * T;
        n = 0;
        while (ifm.finished_o !== 1'b1 && n < 4000) begin
            step(1);
            n++;
        end
        check("done_cycle", cyc, exp_done);
        check("lat", ifm.lat_result_o, (s - e) / T);
        check("stb", ifm.stb_result_o, q);
        last_lat = (s - e) / T;
        last_stb = q;
    endtask

    task automatic release_arm();
        ifm.armed_i = 1'b0;
        step(1);
        check("rel_finished", ifm.finished_o, 1);
        check("rel_lat", ifm.lat_result_o, last_lat);
        check("rel_stb", ifm.stb_result_o, last_stb);
        ifm.trigger_i = 1'b0;
        ifm.sensor_i  = 1'b1;
        step(4);
    endtask

    initial begin
        int tc, e, n;
        ifm.active_i = 1'b1; ifm.armed_i = 1'b0; ifm.mode_i = 2'd0;
        ifm.sensor_i = 1'b1; ifm.vsync_i = 1'b1; ifm.trigger_i = 1'b0;
        ifs.active_i = 1'b1; ifs.armed_i = 1'b0; ifs.mode_i = 2'd0;
        ifs.sensor_i = 1'b1; ifs.vsync_i = 1'b1; ifs.trigger_i = 1'b0;

        // reset state
        step(2);
        check("rst_outputs", {ifm.mode_synced_o, ifm.lat_result_o, ifm.stb_result_o,
                              ifm.trig_waiting_o, ifm.finished_o}, 0);
        reset_n = 1'b1;
        step(4);
        check("idle_outputs", {ifm.trig_waiting_o, ifm.finished_o}, 0);

        // mode 0, light 10 ticks after the reference, held steady
        measure(0, 0, 10 * T - 1, 0);
        check("m0_lat10", ifm.lat_result_o, 10);
        release_arm();

        // mode 1, light 5 ticks after the VSYNC leading edge
        measure(1, 3, 5 * T - 1, 0);
        check("m1_lat5", ifm.lat_result_o, 5);
        release_arm();

        // mode 2 and a noisy sensor after detection
        measure(2, 1, 2 * T + 3, 0);
        release_arm();
        measure(0, 0, 3 * T, 3);
        release_arm();

        // trigger falling in WAIT_REF returns to WAIT_TRIG; VSYNC there is ignored
        ifm.vsync_i = 1'b1;
        ifm.mode_i  = 2'd1;
        ifm.armed_i = 1'b1;
        step(1);
        ifm.trigger_i = 1'b1;
        step(3);
        check("wref_waiting", ifm.trig_waiting_o, 0);
        ifm.trigger_i = 1'b0;
        step(2);
        check("wref_fall_pre", ifm.trig_waiting_o, 0);
        step(1);
        check("wref_back", ifm.trig_waiting_o, 1);
        ifm.vsync_i = 1'b0;
        step(3 + 2 * T);
        check("wtrig_vs_ignored", {ifm.trig_waiting_o, ifm.lat_result_o}, {1'b1, 16'd0});
        ifm.armed_i = 1'b0;
        step(1);
        check("wref_abort", ifm.trig_waiting_o, 0);
        ifm.vsync_i = 1'b1;
        step(4);

        // randomized measurements; the last one is ended by dropping active
        for (int i = 0; i < 6; i++) begin
            measure($urandom_range(0, 3), $urandom_range(0, 30),
                    $urandom_range(0, 15 * T), $urandom_range(0, 4));
            if (i == 5) begin
                ifm.active_i = 1'b0;
                step(1);
                check("inact_finished", ifm.finished_o, 0);
                check("inact_lat", ifm.lat_result_o, last_lat);
                check("inact_stb", ifm.stb_result_o, last_stb);
                ifm.armed_i   = 1'b0;
                ifm.active_i  = 1'b1;
                ifm.trigger_i = 1'b0;
                ifm.sensor_i  = 1'b1;
                step(4);
            end else begin
                release_arm();
            end
        end

        // abort during COUNT_LAT, re-arm with trigger still high, reset in COUNT_STB
        ifm.mode_i  = 2'd3;
        ifm.armed_i = 1'b1;
        step(1);
        ifm.trigger_i = 1'b1;
        step(3 + 2 * T);
        check("abort_pre_lat", ifm.lat_result_o, 2);
        ifm.armed_i = 1'b0;
        step(1);
        check("abort_state", {ifm.trig_waiting_o, ifm.finished_o}, 0);
        check("abort_lat_hold", ifm.lat_result_o, 2);
        step(2 * T);
        check("abort_idle_lat", ifm.lat_result_o, 2);
        ifm.armed_i = 1'b1;
        step(1);
        check("rearm_clear", ifm.lat_result_o, 0);
        step(3 * T);
        check("trig_level_only", {ifm.trig_waiting_o, ifm.lat_result_o}, {1'b1, 16'd0});
        ifm.trigger_i = 1'b0;
        step(4);
        ifm.trigger_i = 1'b1;
        step(3);
        check("retrig_waiting", ifm.trig_waiting_o, 0);
        step(2 * T);
        check("retrig_lat", ifm.lat_result_o, 2);
        ifm.sensor_i = 1'b0;
        step(3 * T);
        check("stb_mode3", ifm.mode_synced_o, 3);
        reset_n = 1'b0;
        #1;
        check("async_rst", {ifm.mode_synced_o, ifm.lat_result_o, ifm.stb_result_o,
                            ifm.trig_waiting_o, ifm.finished_o}, 0);
        ifm.armed_i   = 1'b0;
        ifm.trigger_i = 1'b0;
        ifm.sensor_i  = 1'b1;
        step(1);
        reset_n = 1'b1;
        step(4);

        // latency saturation on the TICK_DIV=1 instance
        ifs.armed_i = 1'b1;
        step(1);
        ifs.trigger_i = 1'b1;
        tc = cyc;
        e  = tc + 3;
        step(3 + 1000);
        check("sat_mid_lat", ifs.lat_result_o, 1000);
        n = 0;
        while (ifs.finished_o !== 1'b1 && n < 70000) begin
            step(1);
            n++;
        end
        check("sat_done_cycle", cyc, e + 65535);
        check("sat_lat", ifs.lat_result_o, 16'hFFFF);
        check("sat_stb", ifs.stb_result_o, 12'hFFF);
        ifs.armed_i   = 1'b0;
        ifs.trigger_i = 1'b0;
        step(4);

        // settle-time saturation: light blinks off every fifth cycle forever
        ifs.armed_i = 1'b1;
        step(1);
        ifs.trigger_i = 1'b1;
        e = cyc + 3;
        step(3);
        n = 0;
        while (ifs.finished_o !== 1'b1 && n < 6000) begin
            ifs.sensor_i = (n % 5 == 4) ? 1'b1 : 1'b0;
            step(1);
            n++;
        end
        check("stbsat_done_cycle", cyc, e + 1 + 4095);
        check("stbsat_stb", ifs.stb_result_o, 12'hFFF);
        check("stbsat_lat", ifs.lat_result_o, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lat_meas_clk27.md
Name: lat_meas_clk27

Overview:
- Single-clock latency tester in the clk27 domain, downstream of the scanconverter output stage.
- Consumes the output VSYNC and the test-patch trigger (DE & G[0]), plus the photodiode sensor input.
- Measures display latency from a mode-selected reference event to light detection, then measures the sensor settle time.
- Results go to the sys controller via the lt_status word.

Parameters:
TICK_DIV, 2700, clk27 cycles per result tick (100 us at 27 MHz)
STABLE_TICKS, 10, consecutive ticks of sensor asserted that count as "stable"
DET_LEVEL, 0, sensor_i level that means light detected (button input is active-low)

Ports:
clk27  in  1  27 MHz measurement clock
reset_n  in  1  asynchronous active-low reset
active_i  in  1  tester mode enabled (sys_ctrl[15])
armed_i  in  1  arm request, level (sys_ctrl[14])
mode_i  in  2  reference select: 0=trigger rise, 1=first VSYNC leading edge after trigger, 2=first VSYNC trailing edge after trigger, 3=as 0
sensor_i  in  1  photodiode/button input, already 2-FF synced
vsync_i  in  1  output VSYNC, asynchronous, active-low
trigger_i  in  1  trigger level from pixel domain, asynchronous, held high while the patch is shown
mode_synced_o  out  2  mode_i latched at arm time
lat_result_o  out  16  latency in ticks
stb_result_o  out  12  settle time in ticks
trig_waiting_o  out  1  armed and waiting for trigger
finished_o  out  1  measurement complete, results valid

Behaviour:
- Reset values: all outputs 0, state IDLE, prescaler 0.
- Input sync: vsync_i and trigger_i each pass through a 2-FF synchronizer plus a prev register. Edges are detected on the synced values, so an edge appears 3 clk27 cycles after the pin changes. VSYNC leading edge = synced 1->0; trailing edge = 0->1.
- Prescaler: counts 0..TICK_DIV-1 and produces a 1-cycle tick at wrap. It resets to 0 on every state entry into COUNT_LAT and COUNT_STB, so the first tick arrives exactly TICK_DIV cycles after entry.
- IDLE: trig_waiting=0.
  - If active_i & armed_i: latch mode_synced_o, clear lat/stb results, clear finished_o, go to WAIT_TRIG.
- WAIT_TRIG: trig_waiting_o=1.
  - On synced trigger rising edge: go to COUNT_LAT if mode is 0 or 3, else go to WAIT_REF.
  - If trigger is already high on entry, wait for the next rise; a level alone does not start a measurement.
- WAIT_REF: trig_waiting_o=0.
  - mode 1: go to COUNT_LAT on VSYNC leading edge.
  - mode 2: go to COUNT_LAT on VSYNC trailing edge.
  - Trigger deasserting here returns to WAIT_TRIG.
- COUNT_LAT:
  - lat_result_o += 1 per tick.
  - When sensor_i==DET_LEVEL (sampled on any cycle), go to COUNT_STB with stable_cnt=0.
  - If lat reaches 0xFFFF (saturate, no wrap): stb=0xFFF, go to DONE.
- COUNT_STB: per tick, stb_result_o += 1 (saturate at 0xFFF).
  - stable_cnt counts ticks with sensor asserted; it resets to 0 on any cycle the sensor is deasserted.
  - When stable_cnt reaches STABLE_TICKS: stb_result_o -= STABLE_TICKS (floor 0), go to DONE.
  - When stb saturates: go to DONE with stb=0xFFF.
- DONE: finished_o=1. Results hold. On armed_i low, go to IDLE; finished_o and the results persist until the next arm.
- If a tick and sensor detection coincide in COUNT_LAT, the tick increment applies before the transition.
- active_i low in any state: go to IDLE next cycle, trig_waiting_o=0, finished_o=0, results hold.
- armed_i low in WAIT_TRIG, WAIT_REF, COUNT_LAT or COUNT_STB: abort to IDLE with finished_o=0.
- reset_n low mid-measurement: all state and outputs clear immediately (async).

Test Plan:
1. Arm with mode 0; raise trigger; drive sensor to DET_LEVEL 27000 cycles after the synced edge, then hold it → lat_result=10, stb_result=0 after 10 more ticks, finished=1, trig_waiting fell at the trigger edge.
2. Arm with mode 1; trigger high; VSYNC leading edge 5000 cycles later; sensor 13500 cycles after that edge → lat_result=5, mode_synced=1.
3. Mode 0: sensor toggles every 1.5 ticks for 20 ticks after detection, then holds → stb_result ≈20 (±1), finished=1.
4. Arm with sensor never asserted → lat saturates to 0xFFFF after 65535 ticks (shorten TICK_DIV=4 in sim), stb=0xFFF, finished=1.
5. Deassert armed during COUNT_LAT → IDLE next cycle, finished=0; re-arm clears results to 0.
6. Trigger already high at arm → no count until trigger falls and rises again; assert reset_n low during COUNT_STB → all outputs 0 the same cycle.
